// File: rtl/multi_rate_counter.sv
// Multi-rate up/down counter with a selectable tick prescaler and active-low 7-segment outputs.
// Define MULTI_RATE_COUNTER_BCD_EN for decimal digits with carry/borrow; otherwise the count is plain binary.
module multi_rate_counter #(
    parameter int NUM_DIGITS = 2,
    parameter int CLK_HZ     = 50000000
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic [1:0]              rate_sel,
    input  logic                    run,
    input  logic                    up,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tick,
    output logic                    wrap,
    output logic [7*NUM_DIGITS-1:0] HEX
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int PW = $clog2(4 * CLK_HZ);

    localparam logic [PW-1:0] TERM_1S = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] TERM_2S = PW'(2 * CLK_HZ - 1);
    localparam logic [PW-1:0] TERM_4S = PW'(4 * CLK_HZ - 1);

    logic          run_en;
    logic [1:0]    rate_q;
    logic [PW-1:0] presc;
    logic [PW-1:0] term;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic          wrap_next;
    logic          tick_q;
    logic          wrap_q;

    always_comb begin
        term = '0;
        case (rate_q)
            2'b00:   term = '0;
            2'b01:   term = TERM_1S;
            2'b10:   term = TERM_2S;
            default: term = TERM_4S;
        endcase
    end

    // Value the counter takes on the next update, plus whether that update wraps.
`ifdef MULTI_RATE_COUNTER_BCD_EN
    logic       carry;
    logic [3:0] digit;

    always_comb begin
        count_next = count_q;
        wrap_next  = 1'b0;
        carry      = 1'b1;
        digit      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit = count_q[4*i +: 4];
            if (carry) begin
                if (up) begin
                    carry = (digit >= 4'd9);
                    digit = carry ? 4'd0 : digit + 4'd1;
                end else begin
                    carry = (digit == 4'd0);
                    digit = carry ? 4'd9 : digit - 4'd1;
                end
            end
            count_next[4*i +: 4] = digit;
        end
        wrap_next = carry;
    end
`else
    always_comb begin
        count_next = count_q;
        wrap_next  = 1'b0;
        if (up) begin
            count_next = count_q + 1'b1;
            wrap_next  = &count_q;
        end else begin
            count_next = count_q - 1'b1;
            wrap_next  = ~|count_q;
        end
    end
`endif

    // run_en holds off all updates for the first edge after reset release; rate_sel is still sampled then.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            run_en  <= 1'b0;
            rate_q  <= 2'b00;
            presc   <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            run_en <= 1'b1;
            rate_q <= rate_sel;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            if (run_en) begin
                if (clear) begin
                    presc   <= '0;
                    count_q <= '0;
                end else if (rate_sel != rate_q) begin
                    presc <= '0;
                end else if (run) begin
                    if (presc == term) begin
                        presc   <= '0;
                        count_q <= count_next;
                        tick_q  <= 1'b1;
                        wrap_q  <= wrap_next;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        s = 7'b1111111;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        HEX = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            HEX[7*i +: 7] = seg7(count_q[4*i +: 4]);
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_multi_rate_counter.sv
// Self-checking bench for multi_rate_counter (CLK_HZ=4, NUM_DIGITS=2): directed scenarios plus random
// stimulus against a cycle-level model that tracks the count as an integer and elapsed cycles per period.
module tb_multi_rate_counter;

    localparam int ND  = 2;
    localparam int CLK = 4;
    localparam int CW  = 4 * ND;
`ifdef MULTI_RATE_COUNTER_BCD_EN
    localparam bit BCD  = 1'b1;
    localparam int MAXV = 10**ND - 1;
`else
    localparam bit BCD  = 1'b0;
    localparam int MAXV = (1 << CW) - 1;
`endif

    logic            CLOCK_50 = 1'b0;
    logic            resetn;
    logic [1:0]      rate_sel;
    logic            run;
    logic            up;
    logic            clear;
    logic [CW-1:0]   count;
    logic            tick;
    logic            wrap;
    logic [7*ND-1:0] HEX;

    int n_checks = 0;
    int n_fail   = 0;

    int m_count;
    int m_elapsed;
    int m_rate;
    bit m_alive;
    bit e_tick;
    bit e_wrap;

    multi_rate_counter #(.NUM_DIGITS(ND), .CLK_HZ(CLK)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .rate_sel (rate_sel),
        .run      (run),
        .up       (up),
        .clear    (clear),
        .count    (count),
        .tick     (tick),
        .wrap     (wrap),
        .HEX      (HEX)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic int period(input int r);
        case (r)
            0:       return 1;
            1:       return CLK;
            2:       return 2 * CLK;
            default: return 4 * CLK;
        endcase
    endfunction

    function automatic logic [CW-1:0] to_hw(input int v);
        logic [CW-1:0] r;
        int rem;
        int base;
        r    = '0;
        rem  = v;
        base = BCD ? 10 : 16;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(rem % base);
            rem = rem / base;
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [7*ND-1:0] exp_hex(input int v);
        logic [CW-1:0]   hw;
        logic [7*ND-1:0] h;
        hw = to_hw(v);
        h  = '0;
        for (int i = 0; i < ND; i++) begin
            h[7*i +: 7] = exp_seg(hw[4*i +: 4]);
        end
        return h;
    endfunction

    function automatic void reset_model();
        m_count   = 0;
        m_elapsed = 0;
        m_rate    = 0;
        m_alive   = 1'b0;
        e_tick    = 1'b0;
        e_wrap    = 1'b0;
    endfunction

    // Predicts the effect of the coming rising edge from the inputs currently applied.
    function automatic void model_step();
        e_tick = 1'b0;
        e_wrap = 1'b0;
        if (!m_alive) begin
            m_alive = 1'b1;
            m_rate  = int'(rate_sel);
        end else if (clear) begin
            m_count   = 0;
            m_elapsed = 0;
            m_rate    = int'(rate_sel);
        end else if (int'(rate_sel) != m_rate) begin
            m_rate    = int'(rate_sel);
            m_elapsed = 0;
        end else if (run) begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed == period(m_rate)) begin
                m_elapsed = 0;
                e_tick    = 1'b1;
                if (up) begin
                    e_wrap  = (m_count == MAXV);
                    m_count = e_wrap ? 0 : m_count + 1;
                end else begin
                    e_wrap  = (m_count == 0);
                    m_count = e_wrap ? MAXV : m_count - 1;
                end
            end
        end
    endfunction

    task automatic tick_clk();
        model_step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; run = 1'b0; up = 1'b1; clear = 1'b0; rate_sel = 2'b00;
        reset_model();
        #2;
        n_checks++; if (count !== '0) begin n_fail++; $display("[TB] FAIL reset_count: got %h expected 00", count); end
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tick: got %b expected 0", tick); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wrap: got %b expected 0", wrap); end
        n_checks++; if (HEX !== {ND{7'b1000000}}) begin n_fail++; $display("[TB] FAIL reset_hex: got %h expected %h", HEX, {ND{7'b1000000}}); end
        run = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #1;
        n_checks++; if ({count, tick} !== {{CW{1'b0}}, 1'b0}) begin n_fail++; $display("[TB] FAIL reset_held: got count=%h tick=%b expected 00/0", count, tick); end
        resetn = 1'b1;
    endtask

    task automatic test_every_cycle();
        run = 1'b1; up = 1'b1; clear = 1'b0; rate_sel = 2'b00;
        for (int i = 1; i <= 20; i++) begin
            tick_clk();
            n_checks++;
            if ({count, tick, wrap} !== {to_hw(m_count), e_tick, e_wrap}) begin
                n_fail++; $display("[TB] FAIL every_cycle[%0d]: got %h/%b/%b expected %h/%b/%b", i, count, tick, wrap, to_hw(m_count), e_tick, e_wrap);
            end
            n_checks++;
            if (tick !== (i > 1)) begin n_fail++; $display("[TB] FAIL every_cycle_tick[%0d]: got %b expected %b", i, tick, (i > 1)); end
        end
        n_checks++; if (count !== to_hw(19)) begin n_fail++; $display("[TB] FAIL every_cycle_final: got %h expected %h", count, to_hw(19)); end
    endtask

    task automatic test_rates();
        clear = 1'b1; rate_sel = 2'b01; up = 1'b1; run = 1'b1;
        tick_clk();
        clear = 1'b0;
        n_checks++; if ({count, tick} !== {to_hw(0), 1'b0}) begin n_fail++; $display("[TB] FAIL rate_clear: got %h/%b expected 00/0", count, tick); end
        for (int i = 1; i <= 16; i++) begin
            tick_clk();
            n_checks++; if (tick !== (i % 4 == 0)) begin n_fail++; $display("[TB] FAIL rate01_tick[%0d]: got %b expected %b", i, tick, (i % 4 == 0)); end
            n_checks++; if (count !== to_hw(m_count)) begin n_fail++; $display("[TB] FAIL rate01_count[%0d]: got %h expected %h", i, count, to_hw(m_count)); end
        end
        rate_sel = 2'b11;
        tick_clk();
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("[TB] FAIL rate11_change: got tick %b expected 0", tick); end
        for (int i = 1; i <= 32; i++) begin
            tick_clk();
            n_checks++; if (tick !== (i % 16 == 0)) begin n_fail++; $display("[TB] FAIL rate11_tick[%0d]: got %b expected %b", i, tick, (i % 16 == 0)); end
        end
        n_checks++; if (count !== to_hw(6)) begin n_fail++; $display("[TB] FAIL rate11_count: got %h expected %h", count, to_hw(6)); end
        rate_sel = 2'b01;
        tick_clk();
        tick_clk();
        tick_clk();
        rate_sel = 2'b10;
        tick_clk();
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("[TB] FAIL midchange_tick: got %b expected 0", tick); end
        for (int i = 1; i <= 8; i++) begin
            tick_clk();
            n_checks++; if (tick !== (i == 8)) begin n_fail++; $display("[TB] FAIL rate10_tick[%0d]: got %b expected %b", i, tick, (i == 8)); end
        end
    endtask

    task automatic test_wrap();
        clear = 1'b1; rate_sel = 2'b00; run = 1'b1; up = 1'b0;
        tick_clk();
        clear = 1'b0;
        tick_clk();
        n_checks++; if ({count, tick, wrap} !== {to_hw(MAXV), 2'b11}) begin n_fail++; $display("[TB] FAIL wrap_down: got %h/%b/%b expected %h/1/1", count, tick, wrap, to_hw(MAXV)); end
        up = 1'b1;
        tick_clk();
        n_checks++; if ({count, tick, wrap} !== {to_hw(0), 2'b11}) begin n_fail++; $display("[TB] FAIL wrap_up: got %h/%b/%b expected 00/1/1", count, tick, wrap); end
        tick_clk();
        n_checks++; if ({count, tick, wrap} !== {to_hw(1), 2'b10}) begin n_fail++; $display("[TB] FAIL wrap_after: got %h/%b/%b expected 01/1/0", count, tick, wrap); end
    endtask

    task automatic test_digits();
        clear = 1'b1; rate_sel = 2'b00; run = 1'b1; up = 1'b1;
        tick_clk();
        clear = 1'b0;
        repeat (10) tick_clk();
        n_checks++; if (count !== (BCD ? 8'h10 : 8'h0A)) begin n_fail++; $display("[TB] FAIL digits_ten: got %h expected %h", count, (BCD ? 8'h10 : 8'h0A)); end
        n_checks++;
        if (HEX !== (BCD ? {7'b1111001, 7'b1000000} : {7'b1000000, 7'b0001000})) begin
            n_fail++; $display("[TB] FAIL digits_hex: got %h expected %h", HEX, (BCD ? {7'b1111001, 7'b1000000} : {7'b1000000, 7'b0001000}));
        end
        up = 1'b0;
        tick_clk();
        n_checks++; if ({count, wrap} !== {8'h09, 1'b0}) begin n_fail++; $display("[TB] FAIL digits_borrow: got %h/%b expected 09/0", count, wrap); end
        n_checks++; if (HEX !== {7'b1000000, 7'b0010000}) begin n_fail++; $display("[TB] FAIL digits_hex9: got %h expected %h", HEX, {7'b1000000, 7'b0010000}); end
    endtask

    task automatic test_clear_run();
        logic [CW-1:0] held;
        clear = 1'b1; rate_sel = 2'b01; run = 1'b1; up = 1'b1;
        tick_clk();
        clear = 1'b0;
        repeat (7) tick_clk();
        n_checks++; if (count !== to_hw(1)) begin n_fail++; $display("[TB] FAIL clear_pre: got %h expected %h", count, to_hw(1)); end
        clear = 1'b1;
        tick_clk();
        clear = 1'b0;
        n_checks++; if ({count, tick, wrap} !== {to_hw(0), 2'b00}) begin n_fail++; $display("[TB] FAIL clear_vs_tick: got %h/%b/%b expected 00/0/0", count, tick, wrap); end
        repeat (6) tick_clk();
        held = count;
        run = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick_clk();
            n_checks++; if ({count, tick, wrap} !== {held, 2'b00}) begin n_fail++; $display("[TB] FAIL frozen[%0d]: got %h/%b/%b expected %h/0/0", i, count, tick, wrap, held); end
        end
        run = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick_clk();
            n_checks++; if (tick !== (i == 2)) begin n_fail++; $display("[TB] FAIL resume_tick[%0d]: got %b expected %b", i, tick, (i == 2)); end
        end
        n_checks++; if (count !== to_hw(2)) begin n_fail++; $display("[TB] FAIL resume_count: got %h expected %h", count, to_hw(2)); end
    endtask

    task automatic test_random();
        clear = 1'b0; rate_sel = 2'b00; run = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) rate_sel = 2'($urandom_range(0, 3));
            clear = ($urandom_range(0, 59) == 0);
            run   = ($urandom_range(0, 9) < 8);
            up    = 1'($urandom);
            tick_clk();
            n_checks++;
            if ({count, tick, wrap, HEX} !== {to_hw(m_count), e_tick, e_wrap, exp_hex(m_count)}) begin
                n_fail++;
                $display("[TB] FAIL random[%0d]: got %h/%b/%b/%h expected %h/%b/%b/%h", i, count, tick, wrap, HEX, to_hw(m_count), e_tick, e_wrap, exp_hex(m_count));
            end
        end
    endtask

    task automatic test_reset_mid();
        int first;
        clear = 1'b0; rate_sel = 2'b00; run = 1'b1; up = 1'b1;
        repeat (5) tick_clk();
        rate_sel = 2'b01;
        repeat (3) tick_clk();
        #3;
        resetn = 1'b0;
        reset_model();
        #1;
        n_checks++;
        if ({count, tick, wrap, HEX} !== {{CW{1'b0}}, 2'b00, {ND{7'b1000000}}}) begin
            n_fail++; $display("[TB] FAIL reset_mid: got %h/%b/%b/%h expected 00/0/0/%h", count, tick, wrap, HEX, {ND{7'b1000000}});
        end
        #2;
        resetn = 1'b1;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            tick_clk();
            if (tick === 1'b1 && first == 0) first = i;
            n_checks++;
            if ({count, tick, wrap} !== {to_hw(m_count), e_tick, e_wrap}) begin
                n_fail++; $display("[TB] FAIL reset_mid_seq[%0d]: got %h/%b/%b expected %h/%b/%b", i, count, tick, wrap, to_hw(m_count), e_tick, e_wrap);
            end
        end
        n_checks++; if (first != 5) begin n_fail++; $display("[TB] FAIL reset_mid_first_tick: got edge %0d expected edge 5", first); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_every_cycle();
        test_rates();
        test_wrap();
        test_digits();
        test_clear_run();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
